// File: rtl/tdoa_sad_estimator.sv
// -----------------------------------------------------------------------------
// tdoa_sad_estimator
//
// Two-microphone time-difference-of-arrival estimator. One frame of DEPTH
// left/right sample pairs is captured through a valid/ready handshake. The
// block then sweeps lags -MAX_LAG..+MAX_LAG and forms, for each lag, the sum of
// absolute differences between a sliding left window and a fixed right window,
// one term per clock. The lag with the smallest SAD is reported together with
// its SAD and a one-hot LED sector. Frames do not overlap: while busy the
// input is back-pressured.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   in_valid      upstream has a sample pair
//   in_ready      block accepts a pair this cycle (FILL state)
//   left_in       left sample, two's-complement
//   right_in      right sample, two's-complement
//   busy          high while computing or reporting
//   result_valid  one-cycle pulse marking a new result
//   result_lag    signed best lag (positive: left lags right)
//   result_sad    SAD at the best lag
//   led_pattern   one-hot sector of the best lag
// -----------------------------------------------------------------------------
module tdoa_sad_estimator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int WINDOW     = 32,
  parameter  int MAX_LAG    = 16,
  parameter  int NUM_LEDS   = 8,
  localparam int SAD_W      = DATA_WIDTH + $clog2(WINDOW),
  localparam int LAG_W      = $clog2(MAX_LAG + 1) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  output logic                  busy,
  output logic                  result_valid,
  output logic [LAG_W-1:0]      result_lag,
  output logic [SAD_W-1:0]      result_sad,
  output logic [NUM_LEDS-1:0]   led_pattern
);

  localparam int N_LAGS = 2 * MAX_LAG + 1;
  localparam int DEPTH  = WINDOW + 2 * MAX_LAG;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int K_W    = $clog2(N_LAGS);
  localparam int J_W    = $clog2(WINDOW);

  typedef enum logic [1:0] {FILL, COMPUTE, REPORT} state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              fill_last;
  logic [ADDR_W-1:0] fill_cnt;
  logic              done;

  assign accept    = in_valid && in_ready;
  assign fill_last = (fill_cnt == ADDR_W'(DEPTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && fill_last) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (done) state_next = REPORT;
      end
      REPORT: begin
        busy       = 1'b1;
        state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame buffers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] left_buf  [DEPTH];
  logic [DATA_WIDTH-1:0] right_buf [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       fill_cnt <= '0;
    else if (accept) fill_cnt <= fill_last ? '0 : fill_cnt + ADDR_W'(1);
  end

  // NOTE: the sample buffers carry no reset; every entry is rewritten before
  // it is read, so resetting them would only cost reset routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      left_buf[fill_cnt]  <= left_in;
      right_buf[fill_cnt] <= right_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Term issue: k walks the lags, j walks the window, one term per cycle.
  // ---------------------------------------------------------------------------
  logic [K_W-1:0] k_cnt;
  logic [J_W-1:0] j_cnt;
  logic           issue_done;
  logic           issue;

  assign issue = (state == COMPUTE) && !issue_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt      <= '0;
      j_cnt      <= '0;
      issue_done <= 1'b0;
    end else if (state != COMPUTE) begin
      k_cnt      <= '0;
      j_cnt      <= '0;
      issue_done <= 1'b0;
    end else if (!issue_done) begin
      if (j_cnt == J_W'(WINDOW - 1)) begin
        j_cnt <= '0;
        if (k_cnt == K_W'(N_LAGS - 1)) issue_done <= 1'b1;
        else                           k_cnt      <= k_cnt + K_W'(1);
      end else begin
        j_cnt <= j_cnt + J_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline: stage 1 read + subtract, stage 2 magnitude, stage 3 accumulate.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]   addr_l, addr_r;
  logic [DATA_WIDTH:0] diff_next;
  logic [DATA_WIDTH:0] abs_full;

  logic                  s1_valid, s1_last_term, s1_last_lag;
  logic [K_W-1:0]        s1_k;
  logic [DATA_WIDTH:0]   s1_diff;
  logic                  s2_valid, s2_last_term, s2_last_lag;
  logic [K_W-1:0]        s2_k;
  logic [DATA_WIDTH-1:0] s2_abs;

  logic [SAD_W-1:0] acc, sad_sum, best_sad;
  logic [K_W-1:0]   best_k;

  always_comb begin
    addr_l = ADDR_W'(k_cnt) + ADDR_W'(j_cnt);
    addr_r = ADDR_W'(MAX_LAG) + ADDR_W'(j_cnt);
    // Sign-extend by one bit so the difference of two extremes cannot wrap.
    diff_next = {left_buf[addr_l][DATA_WIDTH-1], left_buf[addr_l]}
              - {right_buf[addr_r][DATA_WIDTH-1], right_buf[addr_r]};
    abs_full  = s1_diff[DATA_WIDTH] ? (~s1_diff + 1'b1) : s1_diff;
    sad_sum   = acc + SAD_W'(s2_abs);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_last_term <= 1'b0;
      s1_last_lag  <= 1'b0;
      s1_k         <= '0;
      s1_diff      <= '0;
      s2_valid     <= 1'b0;
      s2_last_term <= 1'b0;
      s2_last_lag  <= 1'b0;
      s2_k         <= '0;
      s2_abs       <= '0;
      acc          <= '0;
      best_sad     <= '0;
      best_k       <= '0;
      done         <= 1'b0;
    end else begin
      s1_valid     <= issue;
      s1_last_term <= (j_cnt == J_W'(WINDOW - 1));
      s1_last_lag  <= (k_cnt == K_W'(N_LAGS - 1));
      s1_k         <= k_cnt;
      s1_diff      <= diff_next;

      s2_valid     <= s1_valid;
      s2_last_term <= s1_last_term;
      s2_last_lag  <= s1_last_lag;
      s2_k         <= s1_k;
      // Magnitude of a DATA_WIDTH+1 difference always fits DATA_WIDTH bits.
      s2_abs       <= abs_full[DATA_WIDTH-1:0];

      done <= s2_valid && s2_last_term && s2_last_lag;

      if (s2_valid) begin
        if (s2_last_term) begin
          acc <= '0;
          // Strict less-than keeps the earliest (most negative) lag on ties;
          // the first lag seeds the running best unconditionally.
          if ((s2_k == '0) || (sad_sum < best_sad)) begin
            best_sad <= sad_sum;
            best_k   <= s2_k;
          end
        end else begin
          acc <= sad_sum;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers, loaded on the edge that enters REPORT.
  // ---------------------------------------------------------------------------
  logic [LAG_W-1:0]    lag_next;
  logic [NUM_LEDS-1:0] led_next;

  always_comb begin
    lag_next = LAG_W'(best_k) - LAG_W'(MAX_LAG);
    led_next = NUM_LEDS'(1) << ((int'(best_k) * NUM_LEDS) / N_LAGS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_lag   <= '0;
      result_sad   <= '0;
      led_pattern  <= '0;
    end else if ((state == COMPUTE) && done) begin
      result_valid <= 1'b1;
      result_lag   <= lag_next;
      result_sad   <= best_sad;
      led_pattern  <= led_next;
    end else begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdoa_sad_estimator.sv
// -----------------------------------------------------------------------------
// tb_tdoa_sad_estimator
//
// Directed bench for tdoa_sad_estimator with default parameters. Frames are
// built from hand-chosen patterns whose expected lag, SAD and LED sector are
// worked out by hand; each test task compares the DUT against those values.
// -----------------------------------------------------------------------------
module tb_tdoa_sad_estimator;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 33 * 32 + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       left_in, right_in;
  logic              busy;
  logic              result_valid;
  logic signed [5:0] result_lag;
  logic [20:0]       result_sad;
  logic [7:0]        led_pattern;

  tdoa_sad_estimator dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .left_in      (left_in),
    .right_in     (right_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_lag   (result_lag),
    .result_sad   (result_sad),
    .led_pattern  (led_pattern)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] lvec [DEPTH];
  logic [15:0] rvec [DEPTH];
  logic [15:0] seq  [128];

  // left[n] = right[n - lag] over a random base sequence.
  task automatic build_delay(input int lag);
    for (int i = 0; i < 128; i++) seq[i] = 16'($urandom);
    for (int n = 0; n < DEPTH; n++) begin
      rvec[n] = seq[n + 32];
      lvec[n] = seq[n + 32 - lag];
    end
  endtask

  task automatic build_const(input logic [15:0] l, input logic [15:0] r);
    for (int n = 0; n < DEPTH; n++) begin
      lvec[n] = l;
      rvec[n] = r;
    end
  endtask

  // Drives one frame; returns right before the edge that takes the last pair.
  task automatic send_frame(input bit gaps, output bit timed_out);
    int idx   = 0;
    int guard = 0;
    timed_out = 1'b0;
    while (idx < DEPTH) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        timed_out = 1'b1;
        break;
      end
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        left_in  = 16'hDEAD;
        right_in = 16'hBEEF;
      end else begin
        in_valid = 1'b1;
        left_in  = lvec[idx];
        right_in = rvec[idx];
        if (in_ready) idx++;
      end
    end
  endtask

  // Counts cycles from the last accepting edge to result_valid (bounded).
  task automatic wait_result(input bit hold_valid, output int lat,
                             output bit timed_out, output int ready_viol);
    lat        = -1;
    timed_out  = 1'b1;
    ready_viol = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lat++;
      if (hold_valid) begin
        in_valid = 1'b1;
        left_in  = 16'h5A5A;
        right_in = 16'hA5A5;
      end else begin
        in_valid = 1'b0;
      end
      if (busy && in_ready) ready_viol++;
      if (result_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    left_in  = '0;
    right_in = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_ready, busy, result_valid} !== 3'b100) begin
      n_miss++;
      $display("FAIL reset_ctrl: ready/busy/valid=%b want 100", {in_ready, busy, result_valid});
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({result_lag, result_sad, led_pattern} !== '0) begin
      n_miss++;
      $display("FAIL reset_result: lag=%0d sad=%0d led=%h want 0", result_lag, result_sad, led_pattern);
    end
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_miss++;
      $display("FAIL reset_release: ready/busy=%b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_identical();
    bit to_s, to_w;
    int lat, viol;
    for (int n = 0; n < DEPTH; n++) begin
      lvec[n] = 16'(n * 7);
      rvec[n] = 16'(n * 7);
    end
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || lat !== LATENCY) begin
      n_miss++;
      $display("FAIL ident_latency: got %0d (timeout %0b) want %0d", lat, to_s | to_w, LATENCY);
    end
    n_vec++;
    if (result_lag !== 6'sd0 || result_sad !== 21'd0) begin
      n_miss++;
      $display("FAIL ident_result: lag=%0d sad=%0d want 0/0", result_lag, result_sad);
    end
    n_vec++;
    if (led_pattern !== 8'h08) begin
      n_miss++;
      $display("FAIL ident_led: got %h want 08", led_pattern);
    end
  endtask

  task automatic test_delay_pos();
    bit to_s, to_w;
    int lat, viol;
    build_delay(5);
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || result_lag !== 6'sd5 || result_sad !== 21'd0) begin
      n_miss++;
      $display("FAIL delay_pos: lag=%0d sad=%0d want 5/0", result_lag, result_sad);
    end
    n_vec++;
    if (led_pattern !== 8'h20) begin
      n_miss++;
      $display("FAIL delay_pos_led: got %h want 20", led_pattern);
    end
    // One-cycle pulse; result holds afterwards.
    @(negedge clk);
    n_vec++;
    if (result_valid !== 1'b0 || result_lag !== 6'sd5) begin
      n_miss++;
      $display("FAIL result_hold: valid=%b lag=%0d want 0/5", result_valid, result_lag);
    end
  endtask

  task automatic test_delay_neg();
    bit to_s, to_w;
    int lat, viol;
    build_delay(-16);
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || result_lag !== -6'sd16 || result_sad !== 21'd0) begin
      n_miss++;
      $display("FAIL delay_neg: lag=%0d sad=%0d want -16/0", result_lag, result_sad);
    end
    n_vec++;
    if (led_pattern !== 8'h01) begin
      n_miss++;
      $display("FAIL delay_neg_led: got %h want 01", led_pattern);
    end
  endtask

  task automatic test_tie();
    bit to_s, to_w;
    int lat, viol;
    build_const(16'd100, 16'd40);
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || result_lag !== -6'sd16 || result_sad !== 21'd1920) begin
      n_miss++;
      $display("FAIL tie: lag=%0d sad=%0d want -16/1920", result_lag, result_sad);
    end
    n_vec++;
    if (led_pattern !== 8'h01) begin
      n_miss++;
      $display("FAIL tie_led: got %h want 01", led_pattern);
    end
  endtask

  task automatic test_extremes();
    bit to_s, to_w;
    int lat, viol;
    build_const(16'h7FFF, 16'h8000);
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || result_sad !== 21'd2097120) begin
      n_miss++;
      $display("FAIL extreme_sad: got %0d want 2097120", result_sad);
    end
    n_vec++;
    if (result_lag !== -6'sd16 || led_pattern !== 8'h01) begin
      n_miss++;
      $display("FAIL extreme_lag: lag=%0d led=%h want -16/01", result_lag, led_pattern);
    end
  endtask

  task automatic test_back_to_back();
    bit to_s, to_w;
    int lat, viol;
    // Frame 1: lag -7 -> k=9 -> sector 72/33=2.
    build_delay(-7);
    send_frame(1'b1, to_s);
    wait_result(1'b1, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || lat !== LATENCY) begin
      n_miss++;
      $display("FAIL hs1_latency: got %0d (timeout %0b) want %0d", lat, to_s | to_w, LATENCY);
    end
    n_vec++;
    if (viol !== 0) begin
      n_miss++;
      $display("FAIL hs1_ready: in_ready high while busy for %0d cycles want 0", viol);
    end
    n_vec++;
    if (result_lag !== -6'sd7 || result_sad !== 21'd0 || led_pattern !== 8'h04) begin
      n_miss++;
      $display("FAIL hs1_result: lag=%0d sad=%0d led=%h want -7/0/04", result_lag, result_sad, led_pattern);
    end
    // Frame 2 starts straight after REPORT: lag +3 -> k=19 -> sector 152/33=4.
    build_delay(3);
    send_frame(1'b1, to_s);
    wait_result(1'b1, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || viol !== 0 || lat !== LATENCY) begin
      n_miss++;
      $display("FAIL hs2_flow: lat=%0d viol=%0d want %0d/0", lat, viol, LATENCY);
    end
    n_vec++;
    if (result_lag !== 6'sd3 || result_sad !== 21'd0 || led_pattern !== 8'h10) begin
      n_miss++;
      $display("FAIL hs2_result: lag=%0d sad=%0d led=%h want 3/0/10", result_lag, result_sad, led_pattern);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_compute();
    bit to_s, to_w;
    int lat, viol;
    build_delay(5);
    send_frame(1'b0, to_s);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL midreset_busy: busy=%b before reset want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, result_valid, result_lag, result_sad, led_pattern} !== '0) begin
      n_miss++;
      $display("FAIL midreset_outputs: busy=%b lag=%0d sad=%0d led=%h want 0", busy, result_lag, result_sad, led_pattern);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL midreset_ready: ready=%b busy=%b want 1/0", in_ready, busy);
    end
    // Fresh frame: lag -9 -> k=7 -> sector 56/33=1.
    build_delay(-9);
    send_frame(1'b0, to_s);
    wait_result(1'b0, lat, to_w, viol);
    n_vec++;
    if (to_s || to_w || lat !== LATENCY || result_lag !== -6'sd9 || result_sad !== 21'd0) begin
      n_miss++;
      $display("FAIL midreset_frame: lat=%0d lag=%0d sad=%0d want %0d/-9/0", lat, result_lag, result_sad, LATENCY);
    end
    n_vec++;
    if (led_pattern !== 8'h02) begin
      n_miss++;
      $display("FAIL midreset_led: got %h want 02", led_pattern);
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_delay_pos();
    test_delay_neg();
    test_tie();
    test_extremes();
    test_back_to_back();
    test_reset_mid_compute();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
